// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
//
// Time-multiplexed seven-segment controller for a common-anode display with
// active-low anodes, segments and decimal point. One digit is lit per refresh
// slot of REFRESH_DIV clocks. Display data is double-buffered: a load strobe
// writes a pending buffer, which is copied into the active buffer only at a
// frame boundary (the last tick of the last digit). This keeps a frame from
// showing a mix of old and new data.
//
// Optional feature macro: SEG_LZ_BLANK_EN
//   When defined, leading zeros are suppressed. Suppression is computed from
//   the active buffer. Digit 0 is never suppressed.
//   When undefined, zeros are displayed normally.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   value      hex nibbles, digit k = value[4k+3:4k]
//   dp_in      decimal point request per digit, 1 = lit
//   digit_en   per-digit enable, 0 = blank
//   load       single-cycle strobe, captures value/dp_in/digit_en
//   upd_pend   1 while the pending buffer is not yet committed
//   an         anode enables, active-low, one-hot-zero
//   seg        {A,B,C,D,E,F,G}, active-low
//   dp         decimal point, active-low
//   digit_idx  index of the digit currently driven
// ---------------------------------------------------------------------------
module seg_scan_ctrl #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                                                   clk,
  input  logic                                                   rst_n,
  input  logic [4*NUM_DIGITS-1:0]                                value,
  input  logic [NUM_DIGITS-1:0]                                  dp_in,
  input  logic [NUM_DIGITS-1:0]                                  digit_en,
  input  logic                                                   load,
  output logic                                                   upd_pend,
  output logic [NUM_DIGITS-1:0]                                  an,
  output logic [6:0]                                             seg,
  output logic                                                   dp,
  output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] digit_idx
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pendVal_q, pendVal_d, actVal_q, actVal_d;
  logic [NUM_DIGITS-1:0]   pendDp_q, pendDp_d, actDp_q, actDp_d;
  logic [NUM_DIGITS-1:0]   pendEn_q, pendEn_d, actEn_q, actEn_d;
  logic                    updPend_q, updPend_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [IDX_W-1:0]        digitIdx_q;

  logic                    tick;
  logic                    frameEnd;
  logic [3:0]              curNib;
  logic                    curDp;
  logic                    curEn;
  logic                    curLz;
  logic [NUM_DIGITS-1:0]   anOn;
  logic [NUM_DIGITS-1:0]   lzMask;

  // Active-high ABCDEFG pattern for one hex nibble.
  function automatic logic [6:0] hexPattern(input logic [3:0] nib);
    case (nib)
      4'h0:    hexPattern = 7'b1111110;
      4'h1:    hexPattern = 7'b0110000;
      4'h2:    hexPattern = 7'b1101101;
      4'h3:    hexPattern = 7'b1111001;
      4'h4:    hexPattern = 7'b0110011;
      4'h5:    hexPattern = 7'b1011011;
      4'h6:    hexPattern = 7'b1011111;
      4'h7:    hexPattern = 7'b1110000;
      4'h8:    hexPattern = 7'b1111111;
      4'h9:    hexPattern = 7'b1111011;
      4'hA:    hexPattern = 7'b1110111;
      4'hB:    hexPattern = 7'b0011111;
      4'hC:    hexPattern = 7'b1001110;
      4'hD:    hexPattern = 7'b0111101;
      4'hE:    hexPattern = 7'b1001111;
      default: hexPattern = 7'b1000111;
    endcase
  endfunction

  assign tick     = (cnt_q == CNT_LAST);
  assign frameEnd = tick && (idx_q == IDX_LAST);

  // Refresh counter and scan index. The index wraps after the last digit,
  // so with a single digit it simply stays at 0.
  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Double buffer. A load on the boundary cycle bypasses pending and goes
  // straight to active; otherwise pending is committed at the boundary.
  always_comb begin
    pendVal_d = pendVal_q;
    pendDp_d  = pendDp_q;
    pendEn_d  = pendEn_q;
    actVal_d  = actVal_q;
    actDp_d   = actDp_q;
    actEn_d   = actEn_q;
    updPend_d = updPend_q;
    if (frameEnd) begin
      if (load) begin
        actVal_d  = value;
        actDp_d   = dp_in;
        actEn_d   = digit_en;
        updPend_d = 1'b0;
      end else if (updPend_q) begin
        actVal_d  = pendVal_q;
        actDp_d   = pendDp_q;
        actEn_d   = pendEn_q;
        updPend_d = 1'b0;
      end
    end else if (load) begin
      pendVal_d = value;
      pendDp_d  = dp_in;
      pendEn_d  = digit_en;
      updPend_d = 1'b1;
    end
  end

`ifdef SEG_LZ_BLANK_EN
  logic higherZero;

  // Walk from the most significant digit down; a digit is a leading zero when
  // it is zero and every higher digit is zero or disabled.
  always_comb begin
    lzMask     = '0;
    higherZero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      if ((k != 0) && (actVal_q[4*k +: 4] == 4'h0) && higherZero) begin
        lzMask[k] = 1'b1;
      end
      higherZero = higherZero & ((actVal_q[4*k +: 4] == 4'h0) | ~actEn_q[k]);
    end
  end
`else
  assign lzMask = '0;
`endif

  // Select the active-buffer fields of the digit currently being scanned.
  always_comb begin
    curNib = 4'h0;
    curDp  = 1'b0;
    curEn  = 1'b0;
    curLz  = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        curNib = actVal_q[4*k +: 4];
        curDp  = actDp_q[k];
        curEn  = actEn_q[k];
        curLz  = lzMask[k];
      end
    end
  end

  assign anOn = ~(NUM_DIGITS'(1) << idx_q);

  // Drive for the current digit. A suppressed leading zero keeps its anode
  // on only when its decimal point must still be shown.
  always_comb begin
    an_d  = '1;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (curEn) begin
      if (curLz) begin
        if (curDp) begin
          an_d = anOn;
          dp_d = 1'b0;
        end
      end else begin
        an_d  = anOn;
        seg_d = ~hexPattern(curNib);
        dp_d  = ~curDp;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      pendVal_q  <= '0;
      pendDp_q   <= '0;
      pendEn_q   <= '0;
      actVal_q   <= '0;
      actDp_q    <= '0;
      actEn_q    <= '0;
      updPend_q  <= 1'b0;
      an_q       <= '1;
      seg_q      <= 7'h7F;
      dp_q       <= 1'b1;
      digitIdx_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      pendVal_q  <= pendVal_d;
      pendDp_q   <= pendDp_d;
      pendEn_q   <= pendEn_d;
      actVal_q   <= actVal_d;
      actDp_q    <= actDp_d;
      actEn_q    <= actEn_d;
      updPend_q  <= updPend_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      digitIdx_q <= idx_q;
    end
  end

  assign upd_pend  = updPend_q;
  assign an        = an_q;
  assign seg       = seg_q;
  assign dp        = dp_q;
  assign digit_idx = digitIdx_q;

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed seven-segment display controller for an N-digit common-anode display with active-low anodes and segments. It scans one digit per refresh slot and decodes a 4-bit hex nibble per digit into segment drive. Per-digit decimal points and per-digit blanking are supported. Display data is double-buffered: a load strobe writes a pending buffer, which is committed at a frame boundary so the display never shows a mix of old and new data.

Parameters:
NUM_DIGITS, 8, number of digits scanned (1..16)
REFRESH_DIV, 100000, clock cycles each digit stays lit (>=2)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
value  input  4*NUM_DIGITS  hex nibbles; digit k = value[4k+3:4k]
dp_in  input  NUM_DIGITS  decimal point request per digit, 1 = lit
digit_en  input  NUM_DIGITS  per-digit enable, 0 = blank
load  input  1  single-cycle strobe; captures value/dp_in/digit_en
upd_pend  output  1  1 = pending buffer not yet committed
an  output  NUM_DIGITS  anode enables, active-low, one-hot-zero
seg  output  7  {A,B,C,D,E,F,G}, active-low
dp  output  1  decimal point, active-low
digit_idx  output  $clog2(NUM_DIGITS) (min 1)  index of the digit currently driven

Behaviour:
- Reset (async assert, sync release): refresh cnt=0, idx=0, pending and active buffers all zero (all digits blanked), upd_pend=0, an=all 1, seg=7'h7F, dp=1, digit_idx=0.
- Refresh counter: counts 0..REFRESH_DIV-1 and wraps. tick = (cnt==REFRESH_DIV-1).
- On tick: idx <= (idx==NUM_DIGITS-1) ? 0 : idx+1. Scan order is 0,1,...,N-1,0. With NUM_DIGITS=1, idx stays 0.
- Frame boundary = tick while idx==NUM_DIGITS-1.
- Outputs are registered from the active buffer and the current idx, so there is 1 cycle of latency. an/seg/dp/digit_idx change exactly one cycle after idx changes.
- Digit drive:
  - Enabled digit: an[idx]=0, all other an bits =1.
  - seg = ~hex pattern.
  - dp = ~dp_in[idx].
- Hex pattern, active-high ABCDEFG:
  - 0:1111110  1:0110000  2:1101101  3:1111001
  - 4:0110011  5:1011011  6:1011111  7:1110000
  - 8:1111111  9:1111011  A:1110111  b:0011111
  - C:1001110  d:0111101  E:1001111  F:1000111
- Blanked digit (digit_en[idx]=0): an=all 1, seg=7'h7F, dp=1. Its scan slot is still consumed, which keeps brightness uniform.
- Load:
  - load=1 copies inputs into the pending buffer and sets upd_pend=1.
  - A load while upd_pend=1 overwrites pending (last load wins).
- Commit: at a frame boundary with upd_pend=1, pending → active and upd_pend clears next cycle.
- Load on the boundary cycle: the inputs go straight to active, and upd_pend ends 0.
- No load pending at the boundary: active is unchanged.
- New active data first appears on digit 0 of the next frame.
- Reset mid-frame: immediate return to reset values; any pending update is discarded.

Optional Feature:
- Macro: SEG_LZ_BLANK_EN.
- Defined: leading-zero suppression. Digit k is additionally blanked when its nibble is 0, every higher digit (k+1..N-1) is 0 or disabled, and k != 0. Digit 0 is never suppressed, so all-zero data shows "0". Suppression is computed from the active buffer only. A digit suppressed this way still shows its dp if dp_in[k]=1: an[k]=0, seg=7'h7F, dp=0.
- Undefined: zeros are displayed normally and no suppression logic is built.

Test Plan:
- Reset: hold rst_n=0 for 5 cycles with arbitrary inputs → an=8'hFF, seg=7'h7F, dp=1, upd_pend=0. These hold until a committed load.
- Scan timing (NUM_DIGITS=4, REFRESH_DIV=4):
  - load value=16'h3210, digit_en=4'hF.
  - After commit, an steps 1110→1101→1011→0111→1110, each held 4 cycles; digit_idx matches.
  - seg is 7'b0000001 for digit 0 and 7'b1001111 for digit 1.
- Decode sweep: load each nibble 0..F into digit 0 with digit_en=1 → seg equals the inverse of the table for all 16 values.
  - dp_in=1 → dp=0 only while an[0]=0.
- Double buffer: with 16'h1111 active, pulse load with 16'h2222 mid-frame.
  - upd_pend=1 until the frame boundary.
  - No digit shows 2 before digit 0 of the next frame; from then on all digits show 2.
- Boundary load and overwrite:
  - load asserted on the boundary cycle → new data on the next digit 0, upd_pend stays 0.
  - Two loads in one frame (16'hAAAA then 16'hBBBB) → only B is displayed.
- Blank/LZ (NUM_DIGITS=4): value=16'h0050, digit_en=4'hB.
  - Digit 2 is blanked (an all 1).
  - With SEG_LZ_BLANK_EN, digit 3 is also blanked while digits 1 and 0 show 5 and 0.
  - Without the macro, digit 3 shows 0.
